// File: rtl/sha1_msg_padder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sha1_msg_padder_if
//  Purpose  : Word-stream handshake bundle used on both sides of the SHA-1
//             message padder.
//  Signals  : tvalid - word valid            (master -> slave)
//             tdata  - data word, big-endian (master -> slave)
//             tlast  - last word marker      (master -> slave)
//             tend   - end of padded message (master -> slave, output side only)
//             tready - accept                (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface sha1_msg_padder_if #(
    parameter int WIDTH = 32
);
    logic             tvalid;
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tend;
    logic             tready;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tend,
        input  tready
    );

    // The upstream side carries no end-of-padding marker.
    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/sha1_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module   : sha1_msg_padder
//  Purpose  : Streaming SHA-1 message padder. Forwards 32-bit message words
//             with zero latency, then appends 0x80000000, zero words and the
//             64-bit big-endian bit length so the output is a whole number of
//             16-word blocks. LEN_OFFSET is added to the length (512 for the
//             HMAC inner/outer hashes).
//  Ports    : i_clk  - clock
//             i_rst  - asynchronous active-high reset
//             s_axis - upstream stream  (tvalid_s, tdata_s, tlast_s, tready_s)
//             m_axis - downstream stream(tvalid_m, tdata_m, tlast_m, tend_m,
//                                        tready_m)
//  Revision : 1.0 - initial release
// ============================================================================
module sha1_msg_padder #(
    parameter int          WIDTH      = 32,
    parameter logic [63:0] LEN_OFFSET = 64'd0
) (
    input  wire logic              i_clk,
    input  wire logic              i_rst,
    sha1_msg_padder_if.slave       s_axis,
    sha1_msg_padder_if.master      m_axis
);

    localparam logic [WIDTH-1:0] c_PAD_WORD = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [63:0]      c_WORD_BITS = 64'(WIDTH);

    typedef enum logic [2:0] {
        ST_PASS   = 3'd0,
        ST_PAD80  = 3'd1,
        ST_ZERO   = 3'd2,
        ST_LEN_HI = 3'd3,
        ST_LEN_LO = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_idx;
    logic [63:0]      r_bitcnt;

    logic             w_tvalid;
    logic [WIDTH-1:0] w_tdata;
    logic             w_tend;
    logic             w_tready_s;
    logic             w_out_hs;
    logic             w_in_hs;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_tvalid     = 1'b0;
        w_tdata      = '0;
        w_tend       = 1'b0;
        w_tready_s   = 1'b0;

        unique case (r_state)
            ST_PASS: begin
                // Direct combinational pass-through of the FIFO head.
                w_tready_s = m_axis.tready;
                w_tvalid   = s_axis.tvalid;
                w_tdata    = s_axis.tdata;
                if (s_axis.tvalid && m_axis.tready && s_axis.tlast)
                    w_next_state = ST_PAD80;
            end
            ST_PAD80: begin
                w_tvalid = 1'b1;
                w_tdata  = c_PAD_WORD;
                // At idx 13 the length fits in the same block; otherwise
                // zero-fill up to idx 13 (possibly of the following block).
                if (m_axis.tready)
                    w_next_state = (r_idx == 4'd13) ? ST_LEN_HI : ST_ZERO;
            end
            ST_ZERO: begin
                w_tvalid = 1'b1;
                if (m_axis.tready && (r_idx == 4'd13))
                    w_next_state = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                w_tvalid = 1'b1;
                w_tdata  = r_bitcnt[2*WIDTH-1:WIDTH];
                if (m_axis.tready)
                    w_next_state = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                w_tvalid = 1'b1;
                w_tdata  = r_bitcnt[WIDTH-1:0];
                w_tend   = 1'b1;
                if (m_axis.tready)
                    w_next_state = ST_PASS;
            end
            default: w_next_state = ST_PASS;
        endcase

        // Reset takes effect on the handshake immediately, before the
        // asynchronous register clear is visible through the state decode.
        if (i_rst) begin
            w_tvalid   = 1'b0;
            w_tready_s = 1'b0;
            w_tend     = 1'b0;
        end
    end

    assign w_out_hs = w_tvalid && m_axis.tready;
    assign w_in_hs  = (r_state == ST_PASS) && s_axis.tvalid && w_tready_s;

    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_tdata;
    assign m_axis.tlast  = w_tvalid && (r_idx == 4'd15);
    assign m_axis.tend   = w_tend;
    assign s_axis.tready = w_tready_s;

    // ------------------------------------------------------------------
    // State, block index and bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_PASS;
            r_idx    <= 4'd0;
            r_bitcnt <= LEN_OFFSET;
        end else begin
            r_state <= w_next_state;
            if (w_out_hs)
                r_idx <= r_idx + 4'd1;
            if (w_in_hs)
                r_bitcnt <= r_bitcnt + c_WORD_BITS;
            if (w_out_hs && (r_state == ST_LEN_LO)) begin
                r_bitcnt <= LEN_OFFSET;
                r_idx    <= 4'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sha1_msg_padder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sha1_msg_padder
//  Purpose  : Self-checking bench for sha1_msg_padder. Two instances cover
//             LEN_OFFSET = 0 and LEN_OFFSET = 512; a selector routes the
//             shared stimulus to one of them. Expected words are queued at
//             issue time and popped by an independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sha1_msg_padder;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        fin;
        logic        pad;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        src_valid;
    logic [31:0] src_data;
    logic        src_last;
    logic        tready_m;
    logic        rand_mode;

    exp_t        q[$];
    exp_t        e_mon;
    int          exp_idx;
    int          n_vec;
    int          n_fail;

    logic        hold_pending;
    logic [31:0] hold_data;
    logic        hold_last;
    logic        hold_end;

    logic        mon_valid;
    logic [31:0] mon_data;
    logic        mon_last;
    logic        mon_end;
    logic        mon_tready_s;

    sha1_msg_padder_if #(.WIDTH(32)) up0 ();
    sha1_msg_padder_if #(.WIDTH(32)) dn0 ();
    sha1_msg_padder_if #(.WIDTH(32)) up1 ();
    sha1_msg_padder_if #(.WIDTH(32)) dn1 ();

    assign up0.tvalid = src_valid && !sel;
    assign up0.tdata  = src_data;
    assign up0.tlast  = src_last;
    assign up0.tend   = 1'b0;
    assign up1.tvalid = src_valid && sel;
    assign up1.tdata  = src_data;
    assign up1.tlast  = src_last;
    assign up1.tend   = 1'b0;
    assign dn0.tready = tready_m;
    assign dn1.tready = tready_m;

    sha1_msg_padder #(.WIDTH(32), .LEN_OFFSET(64'd0)) u_dut0 (
        .i_clk  (clk),
        .i_rst  (rst),
        .s_axis (up0),
        .m_axis (dn0)
    );

    sha1_msg_padder #(.WIDTH(32), .LEN_OFFSET(64'd512)) u_dut1 (
        .i_clk  (clk),
        .i_rst  (rst),
        .s_axis (up1),
        .m_axis (dn1)
    );

    always_comb begin
        mon_valid    = sel ? dn1.tvalid : dn0.tvalid;
        mon_data     = sel ? dn1.tdata  : dn0.tdata;
        mon_last     = sel ? dn1.tlast  : dn0.tlast;
        mon_end      = sel ? dn1.tend   : dn0.tend;
        mon_tready_s = sel ? up1.tready : up0.tready;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ready: held high, or randomised each cycle.
    initial begin
        tready_m = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tready_m = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor / scoreboard
    initial begin
        hold_pending = 1'b0;
        hold_data    = '0;
        hold_last    = 1'b0;
        hold_end     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    n_vec++;
                    if (!mon_valid || mon_data !== hold_data ||
                        mon_last !== hold_last || mon_end !== hold_end) begin
                        n_fail++;
                        $display("FAIL hold: valid=%b data=%h last=%b end=%b, required valid=1 data=%h last=%b end=%b",
                                 mon_valid, mon_data, mon_last, mon_end, hold_data, hold_last, hold_end);
                    end
                end
                if (mon_valid && q.size() > 0 && q[0].pad) begin
                    n_vec++;
                    if (mon_tready_s !== 1'b0) begin
                        n_fail++;
                        $display("FAIL tready_s_pad: tready_s=%b, required 0", mon_tready_s);
                    end
                end
                if (mon_valid && tready_m) begin
                    hold_pending = 1'b0;
                    n_vec++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected: data=%h, required no output", mon_data);
                    end else begin
                        e_mon = q.pop_front();
                        if (mon_data !== e_mon.data || mon_last !== e_mon.last ||
                            mon_end !== e_mon.fin) begin
                            n_fail++;
                            $display("FAIL word: data=%h last=%b end=%b, required data=%h last=%b end=%b",
                                     mon_data, mon_last, mon_end, e_mon.data, e_mon.last, e_mon.fin);
                        end
                    end
                end else if (mon_valid) begin
                    hold_pending = 1'b1;
                    hold_data    = mon_data;
                    hold_last    = mon_last;
                    hold_end     = mon_end;
                end else begin
                    hold_pending = 1'b0;
                end
            end
        end
    end

    function automatic void push_exp(input logic [31:0] d, input logic f, input logic p);
        q.push_back('{data: d, last: (exp_idx == 15), fin: f, pad: p});
        exp_idx = (exp_idx + 1) % 16;
    endfunction

    // Queue the full padded response, then drive the message words.
    task automatic send_msg(input int n, input logic [31:0] base, input logic [31:0] len_lo);
        int cnt;
        for (int i = 0; i < n; i++)
            push_exp(base + 32'(i), 1'b0, 1'b0);
        push_exp(32'h8000_0000, 1'b0, 1'b1);
        while (exp_idx != 14)
            push_exp(32'h0, 1'b0, 1'b1);
        push_exp(32'h0, 1'b0, 1'b1);
        push_exp(len_lo, 1'b1, 1'b1);
        exp_idx = 0;

        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_data  = base + 32'(i);
            src_last  = (i == n - 1);
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (!mon_tready_s && cnt < 1000);
            if (!mon_tready_s) begin
                n_vec++;
                n_fail++;
                $display("FAIL accept_timeout: word %0d not accepted, required acceptance", i);
            end
            @(posedge clk);
            #1;
        end
        src_valid = 1'b0;
        src_last  = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while (q.size() != 0 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: %0d words outstanding, required 0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        n_vec++;
        if (mon_valid !== 1'b0 || mon_tready_s !== 1'b0 || mon_last !== 1'b0 || mon_end !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b tready_s=%b last=%b end=%b, required all 0",
                     name, mon_valid, mon_tready_s, mon_last, mon_end);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        exp_idx   = 0;
        sel       = 1'b0;
        rand_mode = 1'b0;
        rst       = 1'b1;
        src_valid = 1'b1;
        src_data  = 32'hDEAD_BEEF;
        src_last  = 1'b1;

        // Reset state with upstream offering a word and downstream ready.
        repeat (3) @(negedge clk);
        check_idle("reset_dut0");
        sel = 1'b1;
        #1;
        check_idle("reset_dut1");
        sel = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        @(posedge clk);
        #1;

        send_msg(1,  32'h0102_0304, 32'h0000_0020);
        drain();
        send_msg(13, 32'h1000_0000, 32'h0000_01A0);
        drain();
        send_msg(14, 32'h2000_0000, 32'h0000_01C0);
        drain();
        send_msg(16, 32'h3000_0000, 32'h0000_0200);
        drain();

        // LEN_OFFSET = 512 with random backpressure and a queued second message.
        sel       = 1'b1;
        rand_mode = 1'b1;
        @(posedge clk);
        #1;
        send_msg(5, 32'h4000_0000, 32'h0000_02A0);
        send_msg(3, 32'h5000_0000, 32'h0000_0260);
        drain();
        rand_mode = 1'b0;
        sel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of zero padding aborts the message.
        send_msg(1, 32'h6000_0000, 32'h0000_0020);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("reset_abort");
        q.delete();
        exp_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_msg(1, 32'h0102_0304, 32'h0000_0020);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha1_msg_padder.md
# sha1_msg_padder

Streaming SHA-1 message padder placed directly downstream of `axis_sync_fifo`. It consumes the 32-bit word stream and its `tlast` marker from the FIFO's master port. It forwards the data words unchanged, then appends the FIPS 180-4 padding: a 0x80000000 word, zero words, and a 64-bit big-endian bit length. The output is a whole number of 16-word (512-bit) blocks for the SHA-1 compression core, and a configurable length offset covers the HMAC key block that has already been hashed.

## Interface
Parameters:
- `WIDTH`, 32, data word width. Only 32 is supported.
- `LEN_OFFSET`, 0, bit count added to the message length. Set it to 512 for the HMAC inner and outer hashes.

Ports:
- `i_clk` input, 1, clock. This block has one clock.
- `i_rst` input, 1, reset. Asynchronous, active-high.
- `tvalid_s` input, 1, upstream word valid.
- `tdata_s` input, 32, upstream word. Big-endian byte order.
- `tlast_s` input, 1, marks the final word of the message.
- `tready_s` output, 1, upstream accept.
- `tvalid_m` output, 1, downstream word valid.
- `tdata_m` output, 32, downstream word.
- `tlast_m` output, 1, marks word index 15 of each 512-bit block.
- `tend_m` output, 1, marks the final word of the padded message (the length low word).
- `tready_m` input, 1, downstream ready.

## Operation
- Messages are whole 32-bit words. A message is at least one word long and `tlast_s` arrives with its final word.
- Internal state:
  - `idx` (4 bits): word index within the current block. It increments on every output handshake and wraps from 15 to 0.
  - `bitcnt` (64 bits): message length in bits. It starts at `LEN_OFFSET` and adds 32 on every accepted input word. It wraps modulo 2^64.
- FSM states are PASS, PAD80, ZERO, LEN_HI and LEN_LO.
- PASS:
  - `tready_s = tready_m`, `tvalid_m = tvalid_s`, `tdata_m = tdata_s`. This path is combinational and adds zero latency.
  - On a handshake with `tlast_s=1`, go to PAD80.
- PAD80:
  - `tready_s=0`, `tvalid_m=1`, `tdata_m=0x80000000`.
  - After the handshake at index p:
    - p ≤ 12: go to ZERO.
    - p = 13: go to LEN_HI.
    - p = 14 or 15: go to ZERO.
- ZERO:
  - `tdata_m=0`, `tvalid_m=1`, `tready_s=0`.
  - Stay in ZERO until the handshake at idx 13, then go to LEN_HI.
  - If PAD80 was at index 14 or 15, ZERO runs to the end of that block and continues through idx 0..13 of the next block.
- LEN_HI: `tdata_m=bitcnt[63:32]` at idx 14. After the handshake, go to LEN_LO.
- LEN_LO:
  - `tdata_m=bitcnt[31:0]` at idx 15, with `tend_m=1`.
  - After the handshake, go to PASS, set `bitcnt` to `LEN_OFFSET` and `idx` to 0.
- `tlast_m` is `(idx==15) && tvalid_m` in every state.
- `tend_m` is asserted only in LEN_LO.
- Upstream is never accepted outside PASS. The next message waits at the FIFO head.

## Timing
- Reset values (while `i_rst` is high):
  - State is PASS, `idx` is 0, `bitcnt` is `LEN_OFFSET`.
  - `tready_s` and `tvalid_m` are forced to 0, and `tlast_m` and `tend_m` are 0.
- Reset has immediate asynchronous effect. Release of reset is synchronous to `i_clk`.
- A reset asserted mid-message or mid-padding aborts it. No further padding words are emitted.
- Output handshake rules:
  - Once `tvalid_m` is high it stays high with stable `tdata_m`, `tlast_m` and `tend_m` until `tready_m` is seen. This holds in all padding states.
  - In PASS this stability depends on the upstream FIFO, which holds its data.
- Padding words are issued back-to-back, one per cycle while `tready_m=1`. There are no bubbles between the last data word and PAD80, or between padding words.
- Number of padding words for a message of N words, with r = N mod 16:
  - r ≤ 13: 16 − r.
  - r = 14 or 15: 32 − r.
- Throughput: one word per cycle while both sides are ready.

## Test plan
- 1 word 0x01020304, `LEN_OFFSET`=0 → 16 outputs: 01020304, 80000000, twelve zero words, 00000000, 00000020. `tlast_m` on the 16th word, with `tend_m` on the same word.
- 13 words → one block. The 80000000 word is at idx 13, then 00000000, 000001A0. `tend_m` fires at idx 15.
- 14 words → 32 outputs: 80000000 at idx 14, zero at idx 15 (`tlast_m`), second block idx 0..13 zero, then 00000000, 000001C0. `tlast_m` is asserted twice and `tend_m` once.
- 16 words → 32 outputs: block 1 is all data with `tlast_m` at word 16. Block 2 is 80000000, 13 zero words, 00000000, 00000200.
- `LEN_OFFSET`=512, 5 words, with `tready_m` toggled randomly → length words 00000000, 000002A0. Each held word stays stable while `tready_m` is low. `tready_s` is 0 throughout padding. A second queued message starts only after `tend_m` is accepted, and its length is computed afresh.
- Assert `i_rst` during ZERO → `tvalid_m` drops to 0 immediately. After release, a 1-word message produces the exact sequence from the first test.
